point_ram_arbiter: RTL
======================

// Module: point_ram_arbiter
// PURPOSE
// Shares the single-port point SRAM (active-low CSB/WEB/OEB) between two requesters:
// - host port: register-file ram_addr/ram_data accesses, used to load and read back points;
// - core port: k-means sequencer point fetches; read-only, burst-oriented.
// Registers every SRAM command. Returns read data with a valid strobe to the owning requester.
// Sits between the k-means core top level and the SRAM macro.
// PARAMETERS
// ADDR_W    9   SRAM address width
// DATA_W    50  SRAM word width
// RD_LAT    1   cycles from SRAM command registered on pins to ram_dout valid (1..3)
// MAX_WAIT  16  host starvation limit in cycles (used only with PRAM_ARB_STARVE_GUARD_EN)
// PORTS
// clk          in   1       clock
// rst_n        in   1       reset: synchronous, active-low
// host_req     in   1       host access request, held until accepted
// host_we      in   1       1 = write, 0 = read
// host_addr    in   ADDR_W  host address
// host_wdata   in   DATA_W  host write data
// host_gnt     out  1       host owns the SRAM port
// host_rdata   out  DATA_W  host read data
// host_rvalid  out  1       host read data valid, 1-cycle pulse
// core_req     in   1       core read request
// core_lock    in   1       hold grant for the core across a burst, even with core_req low
// core_addr    in   ADDR_W  core read address
// core_gnt     out  1       core owns the SRAM port
// core_rdata   out  DATA_W  core read data
// core_rvalid  out  1       core read data valid, 1-cycle pulse
// ram_addr     out  ADDR_W  SRAM address (registered)
// ram_din      out  DATA_W  SRAM write data (registered)
// ram_csb      out  1       SRAM chip select, active-low
// ram_web      out  1       SRAM write enable, active-low
// ram_oeb      out  1       SRAM output enable, active-low
// ram_dout     in   DATA_W  SRAM read data
// busy         out  1       any grant active or read in flight
// BEHAVIOUR
// - Reset values: all *_gnt, *_rvalid and busy = 0; ram_csb = ram_web = ram_oeb = 1;
//   ram_addr, ram_din, *_rdata = 0. Read pipeline is flushed on reset.
// - FSM states: IDLE, GNT_HOST, GNT_CORE.
//   - Grant outputs are registered; the state is decoded into host_gnt / core_gnt.
// - IDLE transitions:
//   - core_req | core_lock -> GNT_CORE. The core has fixed priority on simultaneous requests.
//   - else host_req -> GNT_HOST.
// - GNT_CORE: stays while core_req | core_lock; otherwise -> IDLE.
// - GNT_HOST: stays while host_req & !(core_lock); otherwise -> IDLE.
//   - core_lock rising preempts the host only at a host cycle boundary (after the current acceptance).
// - Every owner change passes through IDLE: one mandatory dead cycle, no back-to-back owner switch.
// - Acceptance: owner req & gnt in cycle N. Next cycle (N+1) the registered outputs drive:
//   - ram_csb = 0, ram_addr = accepted address;
//   - read: ram_oeb = 0, ram_web = 1;
//   - write: ram_web = 0, ram_oeb = 1, ram_din = host_wdata.
// - Cycles with no acceptance drive ram_csb = ram_web = ram_oeb = 1.
// - Read data path:
//   - ram_dout is sampled RD_LAT cycles after N+1 into *_rdata;
//   - the owner's *_rvalid pulses in the following cycle (total read latency RD_LAT + 2 from acceptance).
// - The ID of each in-flight read is carried in an RD_LAT+1 deep shift pipe.
//   - rvalid is routed by tag, not by the current grant, so reads in flight survive an owner switch.
// - Full-throughput bursts: one read accepted per cycle while the owner holds req; no bubbles.
// - busy = gnt | any pipe stage valid. IDLE is not left for a new owner until the pipe is empty
//   only if the new owner writes (prevents a read/write hazard on a shared bus).
// - Reset mid-burst: on the next edge everything returns to reset values; no rvalid is issued for dropped reads.
// - Address is passed through unchanged; no wrap or range check (done by the sequencer).
// CONFIGURATION
// - PRAM_ARB_STARVE_GUARD_EN defined:
//   - a counter increments each cycle host_req is high and not granted;
//   - at MAX_WAIT, the next IDLE decision goes to the host, overriding core priority and core_lock release rules;
//   - GNT_CORE is exited at the next cycle where core_req is low, even if core_lock is high;
//   - the counter clears on host acceptance.
// - Not defined: strict core priority; the host may starve indefinitely under core_lock.
// TESTING
// - Host write 0x1A5 = 50'h3_FFFF_0000_1234, then read 0x1A5:
//   -> WEB low 1 cycle; host_rvalid at RD_LAT+2 after read acceptance with the same data.
// - Core burst of 8 reads at 0x010..0x017 with core_lock = 1:
//   -> 8 consecutive core_rvalid pulses, data in address order, zero bubbles.
// - host_req and core_req rise in the same cycle:
//   -> core_gnt next cycle; host_gnt only after core drops req/lock plus 1 IDLE cycle.
// - Host read accepted in cycle N, core_lock rises at N:
//   -> host_rvalid still delivered; core_gnt no earlier than N+2.
// - rst_n low for 1 cycle mid-burst with 2 reads in flight:
//   -> no rvalid; csb/web/oeb = 1, gnts = 0 the next cycle.
// - With PRAM_ARB_STARVE_GUARD_EN, core_lock held 100 cycles with core_req gaps, host_req high:
//   -> host_gnt within MAX_WAIT + 2 cycles.

Source files
------------

// File: rtl/point_ram_arbiter.sv
// -----------------------------------------------------------------------------
// point_ram_arbiter
//
// Shares the single-port point SRAM (active-low CSB/WEB/OEB) between the host
// register-file port (read/write, used to load and read back points) and the
// k-means core port (read-only, burst fetches). Every SRAM command is
// registered, and read data is returned with a one-cycle valid strobe to the
// requester that issued the read.
//
// Optional feature macro: PRAM_ARB_STARVE_GUARD_EN
//   Defined     : host starvation guard. After MAX_WAIT cycles of an ungranted
//                 host request, the host wins the next IDLE decision and a core
//                 grant is dropped at the first cycle with core_req low, even
//                 while core_lock is held.
//   Not defined : strict core priority; the host may starve under core_lock.
//
// Parameters
//   ADDR_W   SRAM address width
//   DATA_W   SRAM word width
//   RD_LAT   SRAM read latency, command on pins to ram_dout valid (1..3)
//   MAX_WAIT host starvation limit in cycles (starvation guard only)
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   host_req/we/addr/wdata          host request (held until accepted)
//   host_gnt                        host owns the SRAM port
//   host_rdata/host_rvalid          host read return, rvalid is a 1-cycle pulse
//   core_req/lock/addr              core read request, lock holds the grant
//   core_gnt                        core owns the SRAM port
//   core_rdata/core_rvalid          core read return, rvalid is a 1-cycle pulse
//   ram_addr/din/csb/web/oeb        registered SRAM command pins
//   ram_dout                        SRAM read data
//   busy                            a grant is active or a read is in flight
// -----------------------------------------------------------------------------
module point_ram_arbiter #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 50,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   input  logic              core_req,
   input  logic              core_lock,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_gnt,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_csb,
   output logic              ram_web,
   output logic              ram_oeb,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   // Parameter sanity; the pipe slicing below assumes RD_LAT >= 1.
   if (RD_LAT < 1 || RD_LAT > 3 || MAX_WAIT < 1) begin : g_bad_param
      $error("point_ram_arbiter: RD_LAT must be 1..3 and MAX_WAIT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_HOST = 2'd1,
      GNT_CORE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Read tracking: stage 0 is valid in the cycle the read command sits on the
   // pins; stage RD_LAT lines up with ram_dout being valid. The tag (1 = core)
   // travels with each read so returns do not depend on the current owner.
   logic [RD_LAT:0] vld_pipe;
   logic [RD_LAT:0] tag_pipe;
   logic            pipe_busy;

   logic host_acc;
   logic core_acc;
   logic any_acc;
   logic rd_acc;
   logic host_hazard;
   logic starve;

   assign host_gnt  = (state_q == GNT_HOST);
   assign core_gnt  = (state_q == GNT_CORE);
   assign pipe_busy = |vld_pipe;
   assign busy      = host_gnt | core_gnt | pipe_busy;

   assign host_acc = host_gnt & host_req;
   assign core_acc = core_gnt & core_req;
   assign any_acc  = host_acc | core_acc;
   assign rd_acc   = core_acc | (host_acc & ~host_we);

   // A host write must not be granted while reads are still returning on the
   // shared data bus; host reads and core reads may overlap older reads.
   assign host_hazard = host_we & pipe_busy;

`ifdef PRAM_ARB_STARVE_GUARD_EN
   localparam int              CNT_W      = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;

   // Counts cycles the host waits without a grant; saturates at MAX_WAIT and
   // clears only once the host actually gets an access through.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (host_acc) begin
         wait_cnt <= '0;
      end else if (host_req && !host_gnt && (wait_cnt < MAX_WAIT_C)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign starve = host_req & (wait_cnt >= MAX_WAIT_C);
`else
   assign starve = 1'b0;
`endif

   // Next-state logic. Every change of owner goes through IDLE, which gives
   // the mandatory dead cycle between owners.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (starve) begin
               // Starved host overrides core priority; wait in IDLE if the
               // pending access is a write blocked by reads in flight.
               if (!host_hazard) state_d = GNT_HOST;
            end else if (core_req || core_lock) begin
               state_d = GNT_CORE;
            end else if (host_req && !host_hazard) begin
               state_d = GNT_HOST;
            end
         end
         GNT_CORE: begin
            // With a starving host, core_lock no longer holds the grant.
            if (!(core_req || (core_lock && !starve))) state_d = IDLE;
         end
         GNT_HOST: begin
            // core_lock takes effect after the current acceptance edge.
            if (!(host_req && !core_lock)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ram_addr    <= '0;
         ram_din     <= '0;
         ram_csb     <= 1'b1;
         ram_web     <= 1'b1;
         ram_oeb     <= 1'b1;
         vld_pipe    <= '0;
         tag_pipe    <= '0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         core_rdata  <= '0;
         core_rvalid <= 1'b0;
      end else begin
         state_q <= state_d;

         // SRAM command for the access accepted this cycle; idle otherwise.
         ram_csb <= ~any_acc;
         ram_web <= ~(host_acc & host_we);
         ram_oeb <= ~rd_acc;
         if (any_acc) ram_addr <= host_acc ? host_addr : core_addr;
         if (host_acc && host_we) ram_din <= host_wdata;

         vld_pipe <= {vld_pipe[RD_LAT-1:0], rd_acc};
         tag_pipe <= {tag_pipe[RD_LAT-1:0], core_acc};

         // Capture ram_dout when the last stage is valid; rvalid follows by
         // one cycle together with the registered data.
         host_rvalid <= vld_pipe[RD_LAT] & ~tag_pipe[RD_LAT];
         core_rvalid <= vld_pipe[RD_LAT] &  tag_pipe[RD_LAT];
         if (vld_pipe[RD_LAT] && !tag_pipe[RD_LAT]) host_rdata <= ram_dout;
         if (vld_pipe[RD_LAT] &&  tag_pipe[RD_LAT]) core_rdata <= ram_dout;
      end
   end

endmodule
